// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit and its neighbours in execute:
// operation encodings, FSM state encodings, ALU opcode constants and small decode helpers.
package muldiv_pkg;

  localparam int unsigned MD_XLEN = 32;

  // Multiply/divide operation select
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_SIGN = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  // ALU opcodes shared with the control decoder and the combinational ALU
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  // Bit 0 clear selects the signed flavour of both MULT and DIV
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 set selects divide
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: one XLEN+1-bit adder/subtractor plus the HI/LO shift registers.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   load              capture unsigned operand magnitudes and clear the accumulator
//   step              advance one multiply or divide iteration
//   is_div            1 = restoring divide step, 0 = shift-add multiply step
//   a_in, b_in        multiplicand/dividend and multiplier/divisor magnitudes
//   acc_hi, acc_lo    product[2*XLEN-1:XLEN] / remainder and product[XLEN-1:0] / quotient
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] acc_hi,
  output logic [XLEN-1:0] acc_lo
);

  localparam int unsigned AW = XLEN + 1;

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opb_q;

  logic [AW-1:0]   shifted_c;
  logic [AW-1:0]   add_a_c;
  logic [AW-1:0]   add_b_c;
  logic [AW:0]     add_res_c;
  logic [AW-1:0]   mul_sum_c;
  logic            ge_c;

  // Divide: partial remainder with the next dividend bit shifted in
  assign shifted_c = {hi_q, lo_q[XLEN-1]};

  // Shared adder operands: add for multiply, subtract for divide
  always_comb begin
    add_a_c = {1'b0, hi_q};
    add_b_c = {1'b0, opb_q};
    if (is_div) begin
      add_a_c = shifted_c;
      add_b_c = ~{1'b0, opb_q};
    end
  end

  // Extra top bit is the carry; on subtract it means partial remainder >= divisor
  assign add_res_c = {1'b0, add_a_c} + {1'b0, add_b_c} + (AW + 1)'(is_div);
  assign ge_c      = add_res_c[AW];

  // Multiply: add the multiplicand only when the current multiplier bit is set
  assign mul_sum_c = lo_q[0] ? add_res_c[AW-1:0] : {1'b0, hi_q};

  // Accumulator / shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a_in;
      opb_q <= b_in;
    end else if (step) begin
      if (is_div) begin
        hi_q <= ge_c ? add_res_c[XLEN-1:0] : shifted_c[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], ge_c};
      end else begin
        hi_q <= mul_sum_c[AW-1:1];
        lo_q <= {mul_sum_c[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply/divide unit producing HI/LO for MULT, MULTU, DIV, DIVU,
// with MTHI/MTLO write access while idle.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, op         request and operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_val, rt_val    multiplicand/dividend and multiplier/divisor
//   hi_we, lo_we      MTHI / MTLO strobes, wdata their data (ignored while busy)
//   busy              operation in flight
//   done              one-cycle pulse when hi/lo hold a new result
//   hi, lo            HI/LO architectural registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  md_state_e       state_q;
  md_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;

  logic            accept_c;
  logic            step_c;
  logic            idle_c;

  logic            is_div_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            div_zero_q;
  logic [XLEN-1:0] rs_raw_q;

  logic            signed_c;
  logic [XLEN-1:0] rs_mag_c;
  logic [XLEN-1:0] rt_mag_c;

  logic [XLEN-1:0] core_hi;
  logic [XLEN-1:0] core_lo;

  logic [PW-1:0]   prod_c;
  logic [PW-1:0]   prod_fix_c;
  logic [XLEN-1:0] quot_fix_c;
  logic [XLEN-1:0] rem_fix_c;
  logic [XLEN-1:0] res_hi_c;
  logic [XLEN-1:0] res_lo_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and sequencing strobes
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = MD_CALC;
        end
      end
      MD_CALC: begin
        step_c = 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = MD_SIGN;
        end
      end
      MD_SIGN: begin
        state_d = MD_DONE;
      end
      MD_DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = MD_CALC;
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // HI/LO are writable only outside CALC/SIGN
  assign idle_c = (state_q == MD_IDLE) || (state_q == MD_DONE);

  // Registered status outputs follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == MD_CALC) || (state_d == MD_SIGN);
      done <= (state_d == MD_DONE);
    end
  end

  // Iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept_c) begin
      cnt_q <= '0;
    end else if (step_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Operand magnitudes; 0x80000000 maps to itself and is treated as unsigned
  assign signed_c = is_signed_op(op);
  assign rs_mag_c = (signed_c && rs_val[XLEN-1]) ? (~rs_val + XLEN'(1)) : rs_val;
  assign rt_mag_c = (signed_c && rt_val[XLEN-1]) ? (~rt_val + XLEN'(1)) : rt_val;

  // Sign and special-case flags captured with the operands
  always_ff @(posedge clk) begin
    if (rst) begin
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      rs_raw_q   <= '0;
    end else if (accept_c) begin
      is_div_q   <= is_div_op(op);
      neg_q_q    <= signed_c & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
      neg_r_q    <= signed_c & rs_val[XLEN-1];
      div_zero_q <= is_div_op(op) && (rt_val == '0);
      rs_raw_q   <= rs_val;
    end
  end

  muldiv_core #(
    .XLEN   (XLEN)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_c),
    .step   (step_c),
    .is_div (is_div_q),
    .a_in   (rs_mag_c),
    .b_in   (rt_mag_c),
    .acc_hi (core_hi),
    .acc_lo (core_lo)
  );

  // Sign fix-up of the unsigned magnitude result
  assign prod_c     = {core_hi, core_lo};
  assign prod_fix_c = neg_q_q ? (~prod_c + PW'(1)) : prod_c;
  assign quot_fix_c = neg_q_q ? (~core_lo + XLEN'(1)) : core_lo;
  assign rem_fix_c  = neg_r_q ? (~core_hi + XLEN'(1)) : core_hi;

  // Final HI/LO values; divide by zero returns all-ones and the raw dividend
  always_comb begin
    res_hi_c = prod_fix_c[PW-1:XLEN];
    res_lo_c = prod_fix_c[XLEN-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi_c = rs_raw_q;
        res_lo_c = '1;
      end else begin
        res_hi_c = rem_fix_c;
        res_lo_c = quot_fix_c;
      end
    end
  end

  // HI/LO registers: result on entry to DONE, MTHI/MTLO only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state_q == MD_SIGN) begin
      hi <= res_hi_c;
      lo <= res_lo_c;
    end else if (idle_c) begin
      if (hi_we) begin
        hi <= wdata;
      end
      if (lo_we) begin
        lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random operations
// against an arithmetic reference model, and hand-written timing corner cases.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural operands
  function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rhi, output logic [31:0] rlo);
    int              sa;
    int              sb;
    longint          p;
    longint unsigned pu;
    sa = a;
    sb = b;
    case (mop)
      2'b00: begin
        p = longint'(sa) * longint'(sb);
        {rhi, rlo} = p;
      end
      2'b01: begin
        pu = {32'd0, a} * {32'd0, b};
        {rhi, rlo} = pu;
      end
      2'b10: begin
        if (b == 32'd0) begin
          rlo = 32'hFFFF_FFFF; rhi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rlo = 32'h8000_0000; rhi = 32'd0;
        end else begin
          rlo = sa / sb;
          rhi = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          rlo = 32'hFFFF_FFFF; rhi = a;
        end else begin
          rlo = a / b;
          rhi = a % b;
        end
      end
    endcase
  endfunction

  // Present a start request at the current negedge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
  endtask

  // Follow one operation to its done pulse. Cycle c is the c-th cycle after the
  // start edge; done is due at c==34 with busy high in every cycle before it.
  // At cycle 'disturb' a DIVU start and an MTLO write of 0x1234 are pulsed.
  task automatic wait_done(input string name, input logic [31:0] ehi, input logic [31:0] elo,
                           input int disturb, output logic [31:0] hi_c1, output logic [31:0] lo_c20);
    int  lat;
    bit  busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    hi_c1   = 'x;
    lo_c20  = 'x;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (c == 1)  hi_c1  = hi;
      if (c == 20) lo_c20 = lo;
      if (done) begin
        lat = c;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
      if (c == disturb) begin
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd1000;
        rt_val = 32'd3;
        lo_we  = 1'b1;
        wdata  = 32'h1234;
      end
    end
    check({name, " latency"}, 64'(lat), 64'd34);
    check({name, " busy_window"}, 64'(busy_ok), 64'd1);
    check({name, " busy_at_done"}, 64'(busy), 64'd0);
    check({name, " hi"}, 64'(hi), 64'(ehi));
    check({name, " lo"}, 64'(lo), 64'(elo));
  endtask

  // One cycle after done: pulse over, unit idle
  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, " done_pulse"}, 64'(done), 64'd0);
    check({name, " busy_after"}, 64'(busy), 64'd0);
  endtask

  vec_t        vecs[$];
  logic [31:0] ehi;
  logic [31:0] elo;
  logic [31:0] h1;
  logic [31:0] l20;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [1:0]  rop;
  bit          seen_done;
  bit          busy_seen;

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    rs_val = '0;
    rt_val = '0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    wdata  = '0;

    vecs.push_back('{"multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{"div_m7d2",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_big",  2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001});
    vecs.push_back('{"divu_zero", 2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF});
    vecs.push_back('{"div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{"div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0,      32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{"div_7dm2",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    // Directed vector table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, vecs[i].ehi, vecs[i].elo, -1, h1, l20);
      check_idle(vecs[i].name);
    end

    // MTHI / MTLO while idle
    hi_we = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi hi", 64'(hi), 64'hCAFE_0001);
    check("mtlo lo", 64'(lo), 64'h5555);

    // Start and an MTLO pulse mid-flight are ignored
    issue(2'b01, 32'd5, 32'd6);
    wait_done("busy_ignore", 32'd0, 32'd30, 10, h1, l20);
    check("busy_ignore lo_mid", 64'(l20), 64'h5555);
    check_idle("busy_ignore");

    // MTHI in the start cycle lands first, then the result overwrites it
    issue(2'b11, 32'd100, 32'd7);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    wait_done("we_with_start", 32'd2, 32'd14, -1, h1, l20);
    check("we_with_start hi_mid", 64'(h1), 64'hDEAD_BEEF);
    check_idle("we_with_start");

    // Back-to-back: second start accepted in the first DONE cycle
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("b2b_first", 32'd0, 32'd1, -1, h1, l20);
    issue(2'b10, 32'd50, 32'hFFFF_FFF9);
    wait_done("b2b_second", 32'h0000_0001, 32'hFFFF_FFF9, -1, h1, l20);
    check_idle("b2b_second");

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      model(rop, ra, rb, ehi, elo);
      issue(rop, ra, rb);
      wait_done($sformatf("rand%0d op%0d 0x%0h,0x%0h", n, rop, ra, rb), ehi, elo, -1, h1, l20);
    end
    check_idle("rand_tail");

    // Reset mid-operation aborts with no done pulse
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    issue(2'b00, 32'd12345, 32'hFFFF_0000);
    seen_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen_done = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    busy_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
    check("abort no_done", 64'(seen_done), 64'd0);
    check("abort stays_idle", 64'(busy_seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
